pla_ctrl: RTL and testbench



---
 rtl/pla_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pla_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pla_ctrl.sv
// -----------------------------------------------------------------------------
// pla_ctrl: configuration and evaluation controller for a reloadable AND/OR PLA.
//
// A sum-of-products fuse map is streamed in through a valid/ready config port
// (N_TERMS AND rows followed by N_OUT OR rows) into shadow planes. On the last
// OR beat both shadow planes are copied to the active planes in one edge, so
// evaluation never sees a half-written map. Evaluations always use the active
// planes and produce a registered result one cycle after acceptance.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   cfg_start   request a (re)load; honoured in IDLE and RUN only
//   cfg_valid   config beat valid
//   cfg_ready   config beat accepted when cfg_valid && cfg_ready (== busy)
//   cfg_data    AND row (2*N_IN bits) or OR row (low N_TERMS bits)
//   busy        load sequence in progress
//   configured  active planes hold a committed map (sticky until rst)
//   eval_valid  evaluation request
//   eval_ready  equals configured
//   eval_in     PLA input vector
//   out_valid   one-cycle pulse, result valid
//   out_data    PLA result, bit j = output j
// -----------------------------------------------------------------------------
module pla_ctrl #(
  parameter int N_IN    = 3,
  parameter int N_TERMS = 4,
  parameter int N_OUT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2*N_IN-1:0]    cfg_data,
  output logic                 busy,
  output logic                 configured,
  input  logic                 eval_valid,
  output logic                 eval_ready,
  input  logic [N_IN-1:0]      eval_in,
  output logic                 out_valid,
  output logic [N_OUT-1:0]     out_data
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD_AND = 2'd1;
  localparam logic [1:0] S_LOAD_OR  = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  // The row counter is shared by both load phases, so size it for the longer one.
  localparam int CNT_MAX = (N_TERMS > N_OUT) ? N_TERMS : N_OUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] LAST_AND = CW'(N_TERMS - 1);
  localparam logic [CW-1:0] LAST_OR  = CW'(N_OUT - 1);

  logic [1:0]                         state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [N_TERMS-1:0][2*N_IN-1:0]     and_sh_q, and_sh_d;
  logic [N_OUT-1:0][N_TERMS-1:0]      or_sh_q, or_sh_d;
  logic [N_TERMS-1:0][2*N_IN-1:0]     and_act_q, and_act_d;
  logic [N_OUT-1:0][N_TERMS-1:0]      or_act_q, or_act_d;
  logic                               configured_q, configured_d;
  logic                               out_valid_q, out_valid_d;
  logic [N_OUT-1:0]                   out_data_q, out_data_d;

  logic                               loading_s;
  logic                               beat_s;
  logic                               eval_acc_s;
  logic [N_TERMS-1:0]                 terms_s;
  logic [N_OUT-1:0]                   eval_res_s;

  assign loading_s  = (state_q == S_LOAD_AND) || (state_q == S_LOAD_OR);
  assign beat_s     = cfg_valid && loading_s;
  assign eval_acc_s = eval_valid && configured_q;

  assign busy       = loading_s;
  assign cfg_ready  = loading_s;
  assign configured = configured_q;
  assign eval_ready = configured_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // Product terms and OR plane over the active map only.
  always_comb begin
    terms_s    = '1;
    eval_res_s = '0;
    for (int k = 0; k < N_TERMS; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        // A literal that is enabled must be true; enabling both polarities
        // therefore forces the term to 0, and an empty row stays 1.
        terms_s[k] = terms_s[k]
                   & (~and_act_q[k][2*i]   |  eval_in[i])
                   & (~and_act_q[k][2*i+1] | ~eval_in[i]);
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      eval_res_s[j] = |(or_act_q[j] & terms_s);
    end
  end

  // Load FSM, shadow-plane writes and atomic commit to the active planes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    and_sh_d     = and_sh_q;
    or_sh_d      = or_sh_q;
    and_act_d    = and_act_q;
    or_act_d     = or_act_q;
    configured_d = configured_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (cfg_start) begin
          state_d = S_LOAD_AND;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD_AND: begin
        if (beat_s) begin
          and_sh_d[cnt_q] = cfg_data;
          if (cnt_q == LAST_AND) begin
            state_d = S_LOAD_OR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOAD_OR: begin
        if (beat_s) begin
          or_sh_d[cnt_q] = cfg_data[N_TERMS-1:0];
          if (cnt_q == LAST_OR) begin
            // Commit includes the row arriving on this very beat.
            and_act_d    = and_sh_q;
            or_act_d     = or_sh_d;
            configured_d = 1'b1;
            state_d      = S_RUN;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Result register: data holds when no evaluation is accepted.
  always_comb begin
    out_valid_d = eval_acc_s;
    if (eval_acc_s) begin
      out_data_d = eval_res_s;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State and plane registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      and_sh_q     <= '0;
      or_sh_q      <= '0;
      and_act_q    <= '0;
      or_act_q     <= '0;
      configured_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      and_sh_q     <= and_sh_d;
      or_sh_q      <= or_sh_d;
      and_act_q    <= and_act_d;
      or_act_q     <= or_act_d;
      configured_q <= configured_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pla_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pla_ctrl: self-checking bench for pla_ctrl. Directed scenarios from the
// feature list followed by randomized traffic, all compared against a
// behavioural model that keeps the fuse map as a list of received beats.
// -----------------------------------------------------------------------------
module tb_pla_ctrl;

  localparam int NI = 3;
  localparam int NT = 4;
  localparam int NO = 2;

  logic            clk;
  logic            rst;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2*NI-1:0] cfg_data;
  logic            busy;
  logic            configured;
  logic            eval_valid;
  logic            eval_ready;
  logic [NI-1:0]   eval_in;
  logic            out_valid;
  logic [NO-1:0]   out_data;

  pla_ctrl #(.N_IN(NI), .N_TERMS(NT), .N_OUT(NO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .configured (configured),
    .eval_valid (eval_valid),
    .eval_ready (eval_ready),
    .eval_in    (eval_in),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles = 0;

  // Reference model state.
  bit               m_loading;
  bit               m_cfg;
  bit               m_ov;
  logic [NO-1:0]    m_od;
  logic [2*NI-1:0]  beats[$];
  logic [2*NI-1:0]  m_and [NT];
  logic [NT-1:0]    m_or  [NO];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NO-1:0] ref_eval(input logic [NI-1:0] x);
    logic [NO-1:0] r;
    bit t;
    r = '0;
    for (int k = 0; k < NT; k++) begin
      t = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (m_and[k][2*i] && m_and[k][2*i+1]) t = 1'b0;
        else if (m_and[k][2*i] && !x[i])      t = 1'b0;
        else if (m_and[k][2*i+1] && x[i])     t = 1'b0;
      end
      for (int j = 0; j < NO; j++)
        if (t && m_or[j][k]) r[j] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_cfg     = 1'b0;
    m_ov      = 1'b0;
    m_od      = '0;
    beats.delete();
    for (int k = 0; k < NT; k++) m_and[k] = '0;
    for (int j = 0; j < NO; j++) m_or[j] = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busy"},       32'(busy),       32'(m_loading));
    check({tag, ".cfg_ready"},  32'(cfg_ready),  32'(m_loading));
    check({tag, ".configured"}, 32'(configured), 32'(m_cfg));
    check({tag, ".eval_ready"}, 32'(eval_ready), 32'(m_cfg));
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_ov));
    check({tag, ".out_data"},   32'(out_data),   32'(m_od));
  endtask

  // One clock: drive inputs, advance the model with the values sampled at the
  // edge, then compare just after the edge.
  task automatic cycle(input logic st, input logic cv, input logic [2*NI-1:0] cd,
                       input logic ev, input logic [NI-1:0] ei);
    cfg_start  = st;
    cfg_valid  = cv;
    cfg_data   = cd;
    eval_valid = ev;
    eval_in    = ei;
    @(posedge clk);
    if (ev && m_cfg) begin
      m_ov = 1'b1;
      m_od = ref_eval(ei);
    end else begin
      m_ov = 1'b0;
    end
    if (m_loading) begin
      if (cv) begin
        beats.push_back(cd);
        if (beats.size() == NT + NO) begin
          for (int k = 0; k < NT; k++) m_and[k] = beats[k];
          for (int j = 0; j < NO; j++) m_or[j] = beats[NT+j][NT-1:0];
          m_cfg     = 1'b1;
          m_loading = 1'b0;
        end
      end
    end else if (st) begin
      m_loading = 1'b1;
      beats.delete();
    end
    #1;
    if (busy) busy_cycles++;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst.out_valid_async", 32'(out_valid), 32'd0);
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [2*NI-1:0] map_a [NT+NO];
  logic [2*NI-1:0] map_b [NT+NO];

  initial begin
    map_a = '{6'b000101, 6'b100000, 6'b010010, 6'b000011, 6'b000011, 6'b000100};
    map_b = '{6'b000101, 6'b100000, 6'b010010, 6'b000011, 6'b000000, 6'b000001};
    rst = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; eval_valid = 1'b0; eval_in = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outputs("reset");
    rst = 1'b0;

    // Eval before configuration is dropped.
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011);
    check("unconf.eval_ready", 32'(eval_ready), 32'd0);
    check("unconf.out_valid",  32'(out_valid),  32'd0);
    check("unconf.out_data",   32'(out_data),   32'd0);

    // Continuous load of map A.
    busy_cycles = 0;
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int b = 0; b < NT + NO; b++) begin
      cycle(1'b0, 1'b1, map_a[b], 1'b0, '0);
      if (b == NT + NO - 2) check("load.not_yet_cfg", 32'(configured), 32'd0);
    end
    check("load.configured", 32'(configured), 32'd1);
    check("load.busy_cycles", 32'(busy_cycles), 32'd6);

    // Back-to-back evals.
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011); check("b2b.0", 32'(out_data), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b100); check("b2b.1", 32'(out_data), 32'd2);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b101); check("b2b.2", 32'(out_data), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b111); check("b2b.3", 32'(out_data), 32'd1);
    check("b2b.valid", 32'(out_valid), 32'd1);

    // Reload map B with evals of 3'b011 every cycle; start coincides with an eval.
    cycle(1'b1, 1'b0, '0, 1'b1, 3'b011);
    check("reload.start_eval", 32'(out_data), 32'd1);
    for (int b = 0; b < NT + NO; b++) begin
      cycle(1'b0, 1'b1, map_b[b], 1'b1, 3'b011);
      check("reload.during", 32'(out_data), 32'd1);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011);
    check("reload.after", 32'(out_data), 32'd2);

    // Gapped reload of map A: every other cycle idle.
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int b = 0; b < NT + NO; b++) begin
      cycle(1'b0, 1'b0, 6'b111111, 1'b0, '0);
      cycle(1'b0, 1'b1, map_a[b], 1'b0, '0);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011); check("gap.011", 32'(out_data), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b100); check("gap.100", 32'(out_data), 32'd2);

    // Reset during LOAD_OR with an out_valid pending.
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int b = 0; b < NT + 1; b++) cycle(1'b0, 1'b1, map_b[b], 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011);
    check("midrst.pending", 32'(out_valid), 32'd1);
    do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011);
    check("midrst.dropped", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1, 3'b011);
    for (int b = 0; b < NT + NO; b++) begin
      cycle(1'b0, 1'b1, map_a[b], 1'b1, 3'b011);
      if (b < NT + NO - 1) check("midrst.still_dropped", 32'(out_valid), 32'd0);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 3'b011);
    check("midrst.reloaded", 32'(out_data), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
              6'($urandom), 1'($urandom_range(0, 2) != 0), 3'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
